uart_tx_sched: RTL and testbench

Round-robin scheduler that shares one `uart_tx` serializer among `NUM_REQ` independent byte producers. It accepts one byte at a time through per-requester valid/ready handshakes and drives the serializer's `tx_start`/`din` inputs. It tracks frame completion through `tx_done`, enforces an inter-frame gap, and guards against a stalled serializer with a timeout watchdog. It sits between the UART client logic (command, status and debug streams) and the single `uart_tx` instance on the pin.

---
 rtl/uart_tx_sched.sv | 117 +++++++++++
 tb/tb_uart_tx_sched.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin arbiter feeding one uart_tx serializer, with inter-frame gap and tx_done watchdog
module uart_tx_sched #(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 60000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_start,
  output logic [7:0]                 tx_din,
  input  logic                       tx_done,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       frame_done,
  output logic                       timeout_err
);
  localparam int IW       = $clog2(NUM_REQ);
  localparam int WW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW       = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int GAP_LAST = GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;
  logic [1:0]    state_q, state_d;
  logic [7:0]    din_q, din_d;
  logic [IW-1:0] grant_q, grant_d, last_q, last_d, win, cand;
  logic [WW-1:0] wd_q, wd_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          fd_q, fd_d, to_q, to_d, hit;
  logic [7:0]    req_byte [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_byte
    assign req_byte[i] = req_data[8*i +: 8];
  end
  // walk the ring starting just after the last grant; first valid requester wins
  always_comb begin
    win  = '0;
    hit  = 1'b0;
    cand = last_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == IW'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
      if (!hit && req_valid[cand]) begin
        win = cand;
        hit = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    din_d   = din_q;
    grant_d = grant_q;
    last_d  = last_q;
    wd_d    = wd_q;
    gap_d   = gap_q;
    fd_d    = 1'b0;
    to_d    = 1'b0;
    case (state_q)
      ST_IDLE: if (hit) begin
        din_d   = req_byte[win];
        grant_d = win;
        last_d  = win;
        state_d = ST_START;
      end
      ST_START: begin
        wd_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        wd_d  = (wd_q == WW'(TIMEOUT_CYCLES)) ? wd_q : wd_q + 1'b1;
        gap_d = '0;
        if (tx_done) begin
          fd_d    = 1'b1;
          state_d = ST_GAP;
        end else if (wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
          to_d    = 1'b1;
          state_d = ST_GAP;
        end
      end
      default: begin
        gap_d   = gap_q + 1'b1;
        state_d = (GAP_CYCLES == 0 || gap_q == GW'(GAP_LAST)) ? ST_IDLE : ST_GAP;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      din_q   <= 8'h00;
      grant_q <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      wd_q    <= '0;
      gap_q   <= '0;
      fd_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      gap_q   <= gap_d;
      fd_q    <= fd_d;
      to_q    <= to_d;
    end
  end
  // gated by rst so a request is never acknowledged on an edge that resets the scheduler
  assign req_ready   = (state_q == ST_IDLE && hit && !rst) ? NUM_REQ'(1) << win : '0;
  assign tx_start    = state_q == ST_START;
  assign tx_din      = din_q;
  assign busy        = state_q != ST_IDLE;
  assign grant_id    = grant_q;
  assign frame_done  = fd_q;
  assign timeout_err = to_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed bench for uart_tx_sched with a simple serializer model
module tb_uart_tx_sched;
  localparam int G  = 3;
  localparam int TO = 20;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_start, tx_done, busy, frame_done, timeout_err;
  logic [7:0]  tx_din;
  logic [1:0]  grant_id;
  logic        model_done = 1'b0, stray = 1'b0, model_en = 1'b1;
  logic        pfd = 1'b0, pto = 1'b0, pst = 1'b0;
  int          done_delay = 5, mcnt = 0, cyc = 0;
  int          n_tests = 0, n_fail = 0, viol = 0;
  int          fd_cnt = 0, to_cnt = 0, fd_cyc = 0, td_cyc = 0;
  assign tx_done = model_done | stray;
  uart_tx_sched #(.NUM_REQ(4), .GAP_CYCLES(G), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx_start(tx_start), .tx_din(tx_din), .tx_done(tx_done), .busy(busy),
    .grant_id(grant_id), .frame_done(frame_done), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial forever begin
    @(negedge clk);
    model_done = 1'b0;
    if (rst) mcnt = 0;
    else begin
      if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0 && model_en) model_done = 1'b1;
      end
      if (tx_start) mcnt = done_delay;
    end
  end
  initial forever begin
    @(negedge clk);
    #1;
    if ($countones(req_ready) > 1) viol++;
    if (req_ready != 0 && busy) viol++;
    if ((req_ready & ~req_valid) != 0) viol++;
    if ((frame_done && pfd) || (timeout_err && pto) || (tx_start && pst)) viol++;
    if (frame_done && timeout_err) viol++;
    if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
    if (timeout_err) to_cnt++;
    if (tx_done) td_cyc = cyc;
    pfd = frame_done;
    pto = timeout_err;
    pst = tx_start;
  end
  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_rst(input string p);
    chk({p, "_ready"}, req_ready, 0);
    chk({p, "_start"}, tx_start, 0);
    chk({p, "_din"}, tx_din, 8'h00);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_grant"}, grant_id, 0);
    chk({p, "_fd"}, frame_done, 0);
    chk({p, "_to"}, timeout_err, 0);
  endtask
  task automatic do_reset(input bit full);
    rst = 1'b1;
    req_valid = '0;
    stray = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    if (full) chk_rst("rst");
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic wait_ready(output int idx, output int c);
    idx = -1;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (req_ready != 0) break;
      @(negedge clk);
    end
    c = cyc;
    for (int b = 0; b < 4; b++) if (req_ready[b]) idx = b;
    chk("ready_seen", 32'(req_ready != 0), 1);
  endtask
  task automatic wait_busy_low(output int c);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (!busy) break;
    end
    c = cyc;
    chk("idle_seen", 32'(!busy), 1);
  endtask
  task automatic wait_end(output int c);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (frame_done || timeout_err) break;
    end
    c = cyc;
    chk("end_seen", 32'(frame_done || timeout_err), 1);
  endtask
  initial begin
    int s, c, c2, idx, f0, t0, seen;
    req_data = 32'h13121110;
    do_reset(1'b1);
    req_data[23:16] = 8'hA5;
    req_valid = 4'b0100;
    #1;
    chk("t1_ready", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = '0;
    #1;
    s = cyc;
    chk("t1_start", tx_start, 1);
    chk("t1_din", tx_din, 8'hA5);
    chk("t1_grant", grant_id, 2);
    chk("t1_busy", busy, 1);
    @(negedge clk);
    #1;
    chk("t1_start_width", tx_start, 0);
    wait_end(c);
    chk("t1_fd", frame_done, 1);
    chk("t1_fd_lat", c - s, 6);
    chk("t1_td_to_fd", c - td_cyc, 1);
    wait_busy_low(c2);
    chk("t1_gap", c2 - c, G);
    chk("t1_din_hold", tx_din, 8'hA5);
    chk("t1_grant_hold", grant_id, 2);
    req_data[23:16] = 8'h12;
    do_reset(1'b0);
    req_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      wait_ready(idx, c);
      chk($sformatf("rr_%0d", k), idx, k % 4);
      if (k > 0) chk($sformatf("rr_gap_%0d", k), c - fd_cyc, G);
      @(negedge clk);
      if (k == 5) req_valid = '0;
      #1;
      chk($sformatf("rr_din_%0d", k), tx_din, 8'h10 + k % 4);
      @(negedge clk);
    end
    wait_busy_low(c);
    do_reset(1'b0);
    req_valid = 4'b1000;
    wait_ready(idx, c);
    chk("wrap_first", idx, 3);
    @(negedge clk);
    req_valid = 4'b1010;
    wait_ready(idx, c);
    chk("wrap_second", idx, 1);
    @(negedge clk);
    req_valid = 4'b1000;
    wait_ready(idx, c);
    chk("wrap_third", idx, 3);
    @(negedge clk);
    req_valid = 4'b0010;
    repeat (3) @(negedge clk);
    req_valid = '0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (req_ready[1]) seen++;
    end
    chk("withdraw", seen, 0);
    chk("withdraw_idle", busy, 0);
    f0 = fd_cnt;
    @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("stray_idle_fd", fd_cnt - f0, 0);
    chk("stray_idle_busy", busy, 0);
    @(negedge clk);
    req_valid = 4'b0001;
    wait_ready(idx, c);
    chk("stray_gap_grant", idx, 0);
    @(negedge clk);
    req_valid = '0;
    wait_end(c);
    @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    wait_busy_low(c);
    @(negedge clk);
    #1;
    chk("stray_gap_fd", fd_cnt - f0, 1);
    model_en = 1'b0;
    f0 = fd_cnt;
    t0 = to_cnt;
    @(negedge clk);
    req_valid = 4'b0010;
    wait_ready(idx, c);
    chk("wd_grant", idx, 1);
    @(negedge clk);
    req_valid = '0;
    #1;
    s = cyc;
    wait_end(c);
    chk("wd_lat", c - s, TO + 1);
    chk("wd_to", timeout_err, 1);
    chk("wd_no_fd", frame_done, 0);
    wait_busy_low(c2);
    chk("wd_gap", c2 - c, G);
    @(negedge clk);
    #1;
    chk("wd_to_cnt", to_cnt - t0, 1);
    chk("wd_fd_cnt", fd_cnt - f0, 0);
    model_en = 1'b1;
    done_delay = TO;
    f0 = fd_cnt;
    t0 = to_cnt;
    @(negedge clk);
    req_valid = 4'b1000;
    wait_ready(idx, c);
    chk("lim_grant", idx, 3);
    @(negedge clk);
    req_valid = '0;
    #1;
    s = cyc;
    wait_end(c);
    chk("lim_lat", c - s, TO + 1);
    chk("lim_fd", frame_done, 1);
    chk("lim_no_to", timeout_err, 0);
    wait_busy_low(c2);
    @(negedge clk);
    #1;
    chk("lim_to_cnt", to_cnt - t0, 0);
    chk("lim_fd_cnt", fd_cnt - f0, 1);
    done_delay = 5;
    @(negedge clk);
    req_valid = 4'b0100;
    wait_ready(idx, c);
    chk("rm_first", idx, 2);
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    f0 = fd_cnt;
    t0 = to_cnt;
    req_valid = 4'b0101;
    rst = 1'b1;
    #1;
    chk("rm_ready_in_rst", req_ready, 0);
    @(negedge clk);
    #1;
    chk_rst("rm");
    @(negedge clk);
    rst = 1'b0;
    wait_ready(idx, c);
    chk("rm_next", idx, 0);
    chk("rm_no_fd", fd_cnt - f0, 0);
    chk("rm_no_to", to_cnt - t0, 0);
    @(negedge clk);
    req_valid = 4'b0100;
    wait_ready(idx, c);
    chk("rm_after", idx, 2);
    @(negedge clk);
    req_valid = '0;
    wait_busy_low(c);
    chk("invariants", viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
